// File: rtl/tlul_pkg.sv
// TL-UL channel types plus the per-slot state used by the reorder buffer.
// Handshake rule for every channel in these structs: a beat transfers on a
// rising clock edge where valid and ready are both 1. Once valid is raised,
// the payload stays stable and valid stays high until that edge.
package tlul_pkg;
  import top_pkg::*;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // Life cycle of one reorder slot: Free -> Pending -> Filled -> Free.
  typedef enum logic [1:0] {
    Free    = 2'd0,
    Pending = 2'd1,
    Filled  = 2'd2
  } slot_state_e;
endpackage

// File: rtl/top_pkg.sv
// Top-level TL-UL bus geometry shared by every TL-UL block.
// Widths only, no logic.
package top_pkg;
  localparam int TL_AW  = 32;  // address width
  localparam int TL_DW  = 32;  // data width
  localparam int TL_AIW = 8;   // A-channel source id width
  localparam int TL_DIW = 1;   // D-channel sink id width
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;   // log2 of max transfer size in bytes
endpackage

// File: rtl/tlul_rsp_reorder_buffer_if.sv
// One TL-UL link: h2d carries A-channel requests and d_ready, d2h carries
// D-channel responses and a_ready.
// Modports:
//   master - the side issuing requests (drives h2d, receives d2h)
//   slave  - the side serving requests (receives h2d, drives d2h)
interface tlul_rsp_reorder_buffer_if;
  import tlul_pkg::*;

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_rob_tag_cam.sv
// Tag store and slot-state machine for the reorder buffer.
// Holds one source tag and one slot_state_e per slot, and answers two
// questions every cycle:
//   match_oh_o - which Pending slot owns the incoming d_source (one-hot,
//                at most one bit since outstanding sources are unique)
//   clash_o    - whether the incoming a_source is still outstanding
//                (Pending or Filled) and therefore must not be accepted
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   alloc_i/alloc_idx_i/alloc_tag_i   reserve slot as Pending with tag
//   lookup_i/lookup_tag_i         response arrives with this d_source
//   release_i/release_idx_i       head slot handed to host, becomes Free
//   clash_tag_i                   a_source of the request on offer
//   match_oh_o, clash_o           CAM results
//   state_o                       current state of every slot (also debug)
module tlul_rob_tag_cam
  import tlul_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH),
  localparam int AIW = top_pkg::TL_AIW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_i,
  input  logic [IW-1:0]     alloc_idx_i,
  input  logic [AIW-1:0]    alloc_tag_i,
  input  logic              lookup_i,
  input  logic [AIW-1:0]    lookup_tag_i,
  input  logic              release_i,
  input  logic [IW-1:0]     release_idx_i,
  input  logic [AIW-1:0]    clash_tag_i,
  output logic [DEPTH-1:0]  match_oh_o,
  output logic              clash_o,
  output slot_state_e       state_o [DEPTH]
);

  slot_state_e           state_q [DEPTH];
  slot_state_e           state_d [DEPTH];
  logic [AIW-1:0]        tag_q   [DEPTH];
  logic [AIW-1:0]        tag_d   [DEPTH];

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= Free;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  // Next-state logic. Alloc only hits a Free slot, fill only a Pending one
  // and release only a Filled one, so the three updates never collide on
  // the same slot in one cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      tag_d[i]   = tag_q[i];
      if (alloc_i && alloc_idx_i == IW'(i)) begin
        state_d[i] = Pending;
        tag_d[i]   = alloc_tag_i;
      end
      if (match_oh_o[i]) begin
        state_d[i] = Filled;
      end
      if (release_i && release_idx_i == IW'(i)) begin
        state_d[i] = Free;
      end
    end
  end

  // Outputs. The clash check looks at registered state, so a slot being
  // released this cycle still blocks its tag until the next cycle.
  always_comb begin
    match_oh_o = '0;
    clash_o    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      state_o[i] = state_q[i];
      if (lookup_i && state_q[i] == Pending && tag_q[i] == lookup_tag_i) begin
        match_oh_o[i] = 1'b1;
      end
      if (state_q[i] != Free && tag_q[i] == clash_tag_i) begin
        clash_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlul_rsp_reorder_buffer.sv
// TL-UL response reorder buffer.
// Requests from an in-order host pass straight through to an out-of-order
// device path; each accepted request reserves the slot at wr_ptr. Responses
// come back in any order, are matched to their slot by d_source, parked,
// and handed to the host strictly in request order from rd_ptr.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   host                host link (host_i = host.h2d, host_o = host.d2h)
//   device              device link (device_o = device.h2d, device_i = device.d2h)
//   occupancy_o         number of slots not Free, registered
//   unexpected_rsp_o    1-cycle pulse after a response matched no Pending slot
module tlul_rsp_reorder_buffer
  import tlul_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  tlul_rsp_reorder_buffer_if.slave    host,
  tlul_rsp_reorder_buffer_if.master   device,
  output logic [PW-1:0]               occupancy_o,
  output logic                        unexpected_rsp_o
);

  tl_h2d_t host_i;
  tl_d2h_t host_o;
  tl_h2d_t device_o;
  tl_d2h_t device_i;

  assign host_i     = host.h2d;
  assign host.d2h   = host_o;
  assign device.h2d = device_o;
  assign device_i   = device.d2h;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occupancy_q, occupancy_d;
  logic          unexpected_q, unexpected_d;
  tl_d2h_t       rsp_q [DEPTH];
  tl_d2h_t       rsp_d [DEPTH];

  logic [IW-1:0]    wr_idx, rd_idx;
  logic             full, clash, a_ok, accept, head_filled, release_head;
  logic [DEPTH-1:0] match_oh;
  slot_state_e      slot_state [DEPTH];

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];
  assign full   = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);

  tlul_rob_tag_cam #(.DEPTH(DEPTH)) u_tag_cam (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (accept),
    .alloc_idx_i   (wr_idx),
    .alloc_tag_i   (host_i.a_source),
    .lookup_i      (device_i.d_valid),
    .lookup_tag_i  (device_i.d_source),
    .release_i     (release_head),
    .release_idx_i (rd_idx),
    .clash_tag_i   (host_i.a_source),
    .match_oh_o    (match_oh),
    .clash_o       (clash),
    .state_o       (slot_state)
  );

  // A channel: combinational pass-through, gated while full, while the
  // source is still outstanding, and while in reset.
  assign a_ok   = ~rst_i & ~full & ~clash;
  assign accept = device_o.a_valid & device_i.a_ready;

  always_comb begin
    device_o         = host_i;
    device_o.a_valid = host_i.a_valid & a_ok;
    // A slot was reserved at request time, so every response has a home.
    device_o.d_ready = 1'b1;
  end

  // D channel to host: only the head slot may be presented. The payload
  // comes from the stored array, so there is no capture-to-host bypass.
  assign head_filled  = slot_state[rd_idx] == Filled;
  assign release_head = head_filled & host_i.d_ready;

  always_comb begin
    host_o = '0;
    if (head_filled) begin
      host_o         = rsp_q[rd_idx];
      host_o.d_valid = 1'b1;
    end
    host_o.a_ready = device_i.a_ready & a_ok;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rsp_d[i] = match_oh[i] ? device_i : rsp_q[i];
    end
    wr_ptr_d     = wr_ptr_q + PW'(accept);
    rd_ptr_d     = rd_ptr_q + PW'(release_head);
    occupancy_d  = wr_ptr_d - rd_ptr_d;
    unexpected_d = device_i.d_valid & ~(|match_oh);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occupancy_q  <= '0;
      unexpected_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rsp_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occupancy_q  <= occupancy_d;
      unexpected_q <= unexpected_d;
      for (int i = 0; i < DEPTH; i++) begin
        rsp_q[i] <= rsp_d[i];
      end
    end
  end

  assign occupancy_o      = occupancy_q;
  assign unexpected_rsp_o = unexpected_q;

endmodule

// File: tb/tb_tlul_rsp_reorder_buffer.sv
// Bench for tlul_rsp_reorder_buffer (DEPTH=4). Inputs change 1 ns after the
// rising edge; checks run 2 ns after it; the output monitor samples at the
// falling edge. The reference model is simply the list of outstanding
// requests in acceptance order (exp_q) plus a device model holding the
// requests it has not answered yet (dev_pend).
module tb_tlul_rsp_reorder_buffer;
  import tlul_pkg::*;

  localparam int DEPTH = 4;
  localparam int W = 40;  // {source[7:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic        h_a_valid = 1'b0;
  logic [7:0]  h_src = '0;
  logic [31:0] h_data = '0;
  logic        h_d_ready = 1'b0;
  logic        dv_a_ready = 1'b0;
  logic        dv_d_valid = 1'b0;
  logic [7:0]  dv_src = '0;
  logic [31:0] dv_data = '0;

  logic [2:0]  occ;
  logic        unexp;

  tlul_rsp_reorder_buffer_if host_bus ();
  tlul_rsp_reorder_buffer_if dev_bus ();

  always_comb begin
    host_bus.h2d          = '0;
    host_bus.h2d.a_valid  = h_a_valid;
    host_bus.h2d.a_opcode = Get;
    host_bus.h2d.a_size   = 2'd2;
    host_bus.h2d.a_source = h_src;
    host_bus.h2d.a_mask   = 4'hF;
    host_bus.h2d.a_data   = h_data;
    host_bus.h2d.d_ready  = h_d_ready;
  end

  always_comb begin
    dev_bus.d2h          = '0;
    dev_bus.d2h.d_valid  = dv_d_valid;
    dev_bus.d2h.d_opcode = AccessAckData;
    dev_bus.d2h.d_size   = 2'd2;
    dev_bus.d2h.d_source = dv_src;
    dev_bus.d2h.d_data   = dv_data;
    dev_bus.d2h.a_ready  = dv_a_ready;
  end

  tlul_rsp_reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .host             (host_bus),
    .device           (dev_bus),
    .occupancy_o      (occ),
    .unexpected_rsp_o (unexp)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           dev_pend[$];
  logic [31:0]  dev_data [256];
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handed to the host must be the oldest
  // outstanding request's source with the data the device returned for it.
  always @(negedge clk) begin
    if (!rst && host_bus.d2h.d_valid && h_d_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_order: got src %0h data %0h, nothing outstanding",
                 host_bus.d2h.d_source, host_bus.d2h.d_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({host_bus.d2h.d_source, host_bus.d2h.d_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL rsp_order: got src %0h data %0h expected src %0h data %0h",
                   host_bus.d2h.d_source, host_bus.d2h.d_data, mon_exp[39:32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call after inputs are set and settled: records an accept that will
  // happen on the coming edge, then advances to 1 ns after that edge.
  task automatic step();
    logic [31:0] r;
    if (!rst && h_a_valid && host_bus.d2h.a_ready) begin
      chk("dev_a_valid", 64'(dev_bus.h2d.a_valid), 64'd1);
      chk("dev_a_source", 64'(dev_bus.h2d.a_source), 64'(h_src));
      r = $urandom;
      dev_data[h_src] = r;
      exp_q.push_back({h_src, r});
      dev_pend.push_back(int'(h_src));
    end
    @(posedge clk);
    #1;
    dv_d_valid = 1'b0;
    h_a_valid  = 1'b0;
  endtask

  task automatic send_rsp(input int src);
    for (int i = 0; i < dev_pend.size(); i++) begin
      if (dev_pend[i] == src) begin
        dev_pend.delete(i);
        break;
      end
    end
    dv_d_valid = 1'b1;
    dv_src     = 8'(src);
    dv_data    = dev_data[8'(src)];
  endtask

  task automatic issue(input logic [7:0] src);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      h_a_valid = 1'b1;
      h_src     = src;
      h_data    = $urandom;
      #1;
      if (host_bus.d2h.a_ready) done = 1'b1;
      step();
    end
    chk("issue_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int idx;
    h_d_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      if (dev_pend.size() > 0) begin
        idx = $urandom_range(0, dev_pend.size() - 1);
        send_rsp(dev_pend[idx]);
      end
      #1;
      step();
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_occ", 64'(occ), 64'd0);
    step();
  endtask

  // ---------------- main sequence ----------------
  logic        exp_ready;
  logic [51:0] snap;

  initial begin
    // Reset with a request on offer and a ready device: nothing may leak.
    rst = 1'b1; h_a_valid = 1'b1; h_src = 8'd7; dv_a_ready = 1'b1; h_d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_valid", 64'(host_bus.d2h.d_valid), 64'd0);
    chk("rst_a_ready", 64'(host_bus.d2h.a_ready), 64'd0);
    chk("rst_dev_a_valid", 64'(dev_bus.h2d.a_valid), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_unexp", 64'(unexp), 64'd0);
    rst = 1'b0; h_a_valid = 1'b0;
    @(posedge clk); #1;

    // Responses 3,1,2 for requests 1,2,3: 3 parks until 1 and 2 go out.
    issue(8'd1); issue(8'd2); issue(8'd3);
    send_rsp(3); #1; step();
    for (int k = 0; k < 2; k++) begin
      #1; chk("parked_no_valid", 64'(host_bus.d2h.d_valid), 64'd0); step();
    end
    h_d_ready = 1'b0;
    send_rsp(1); #1; step();
    #1;
    chk("head_src1", 64'(host_bus.d2h.d_source), 64'd1);
    chk("head_valid1", 64'(host_bus.d2h.d_valid), 64'd1);
    send_rsp(2); #1; step();
    drain();

    // Full: the fifth request stalls until the first release.
    issue(8'd10); issue(8'd11); issue(8'd12); issue(8'd13);
    h_a_valid = 1'b1; h_src = 8'd14; #1;
    chk("full_a_ready", 64'(host_bus.d2h.a_ready), 64'd0);
    chk("full_occ", 64'(occ), 64'd4);
    step();
    send_rsp(10); h_a_valid = 1'b1; h_src = 8'd14; #1;
    chk("full_a_ready2", 64'(host_bus.d2h.a_ready), 64'd0);
    step();
    h_a_valid = 1'b1; #1;
    chk("full_head_valid", 64'(host_bus.d2h.d_valid), 64'd1);
    chk("full_a_ready_on_release", 64'(host_bus.d2h.a_ready), 64'd0);
    step();
    h_a_valid = 1'b1; #1;
    chk("a_ready_after_release", 64'(host_bus.d2h.a_ready), 64'd1);
    step();
    drain();

    // Source clash: 5 must wait until its old slot is freed, one cycle late.
    h_d_ready = 1'b1;
    issue(8'd5);
    h_d_ready = 1'b0;
    send_rsp(5); #1; step();
    for (int k = 0; k < 2; k++) begin
      h_a_valid = 1'b1; h_src = 8'd5; #1;
      chk("clash_stall", 64'(host_bus.d2h.a_ready), 64'd0);
      step();
    end
    h_d_ready = 1'b1; h_a_valid = 1'b1; h_src = 8'd5; #1;
    chk("clash_same_cycle_release", 64'(host_bus.d2h.a_ready), 64'd0);
    step();
    h_a_valid = 1'b1; h_src = 8'd5; #1;
    chk("clash_cleared", 64'(host_bus.d2h.a_ready), 64'd1);
    step();
    drain();

    // Unexpected response: one-cycle pulse, nothing reaches the host.
    dv_d_valid = 1'b1; dv_src = 8'd9; dv_data = 32'hDEAD_BEEF; #1; step();
    #1;
    chk("unexp_pulse", 64'(unexp), 64'd1);
    chk("unexp_no_valid", 64'(host_bus.d2h.d_valid), 64'd0);
    step();
    #1;
    chk("unexp_single_cycle", 64'(unexp), 64'd0);
    chk("unexp_occ", 64'(occ), 64'd0);
    step();

    // Host back-pressure: head held stable while traffic continues.
    h_d_ready = 1'b1;
    issue(8'd20); issue(8'd21);
    h_d_ready = 1'b0;
    send_rsp(20); #1; step();
    snap = {host_bus.d2h.d_valid, host_bus.d2h.d_opcode, host_bus.d2h.d_source, host_bus.d2h.d_data, 8'h0};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin h_a_valid = 1'b1; h_src = 8'd22; end
      if (k == 1) send_rsp(21);
      #1;
      chk("stall_stable", 64'({host_bus.d2h.d_valid, host_bus.d2h.d_opcode, host_bus.d2h.d_source,
                               host_bus.d2h.d_data, 8'h0}), 64'(snap));
      if (k == 0) chk("stall_new_req", 64'(host_bus.d2h.a_ready), 64'd1);
      step();
    end
    #1;
    chk("stall_head_src", 64'(host_bus.d2h.d_source), 64'd20);
    chk("stall_occ", 64'(occ), 64'd3);
    step();
    drain();

    // Reset mid-operation drops everything; the old tags become free.
    h_d_ready = 1'b1;
    issue(8'd30); issue(8'd31);
    send_rsp(30);
    rst = 1'b1; #1;
    chk("midrst_occ", 64'(occ), 64'd0);
    chk("midrst_d_valid", 64'(host_bus.d2h.d_valid), 64'd0);
    chk("midrst_a_ready", 64'(host_bus.d2h.a_ready), 64'd0);
    exp_q.delete(); dev_pend.delete();
    step();
    rst = 1'b0;
    @(posedge clk); #1;
    issue(8'd30);
    drain();

    // Randomized traffic against the outstanding-list model.
    for (int c = 0; c < 600; c++) begin
      h_d_ready  = ($urandom_range(0, 3) != 0);
      dv_a_ready = ($urandom_range(0, 4) != 0);
      h_a_valid  = $urandom_range(0, 1);
      h_src      = 8'($urandom_range(0, 11));
      h_data     = $urandom;
      if (dev_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        send_rsp(dev_pend[$urandom_range(0, dev_pend.size() - 1)]);
      end
      #1;
      exp_ready = dv_a_ready && (exp_q.size() < DEPTH);
      foreach (exp_q[i]) if (exp_q[i][39:32] == h_src) exp_ready = 1'b0;
      chk("rand_a_ready", 64'(host_bus.d2h.a_ready), 64'(exp_ready));
      chk("rand_occ", 64'(occ), 64'(exp_q.size()));
      chk("rand_unexp", 64'(unexp), 64'd0);
      step();
    end
    dv_a_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit in case a handshake never completes.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
